rst_sequencer: RTL and testbench

Reset release sequencer driven from the synchronized system reset. It holds NUM_DOMAINS downstream reset outputs (active-low, one per subsystem) asserted for a programmable hold period, then releases them one at a time in index order with a fixed gap between releases. It also services single-cycle soft-reset requests that re-run the full assert/release sequence. It sits directly after the reset synchronizer in each clock domain, and its outputs feed the subsystem reset pins (register file, ALU, UART, FIFO, etc.).

---
 rtl/rst_sequencer.sv | 167 ++++++++++++++++
 tb/tb_rst_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Reset release sequencer placed after the reset synchronizer. It holds
// NUM_DOMAINS active-low subsystem resets asserted for HOLD_CYCLES cycles. It
// then releases them one at a time, lowest index first, with GAP_CYCLES cycles
// between releases. GAP_CYCLES after the last release it reports seq_done.
// A single-cycle soft_req re-runs the whole assert/release sequence. A
// soft-initiated sequence ends with a one-cycle soft_ack pulse.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset, overrides everything
//   soft_req   in   single-cycle soft-reset request pulse
//   dom_rst_n  out  [NUM_DOMAINS-1:0] per-domain reset, active-low
//   seq_done   out  high while all domains are released and sequencer idle
//   soft_ack   out  one-cycle pulse when a soft-initiated sequence completes
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   soft_req,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   seq_done,
    output logic                   soft_ack
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_HG) + 1;
    localparam int IDX_W  = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                 state_reg,   state_next;
    logic [CNT_W-1:0]       cnt_reg,     cnt_next;
    logic [IDX_W-1:0]       idx_reg,     idx_next;
    logic [NUM_DOMAINS-1:0] dom_reg,     dom_next;
    logic                   done_reg,    done_next;
    logic                   ack_reg,     ack_next;
    logic                   pending_reg, pending_next;
    logic                   src_reg,     src_next;

    // Release strobe for a single domain plus a global clear; the per-bit
    // update below turns these into the next dom_rst_n value.
    logic                   rel_en;
    logic [IDX_W-1:0]       rel_idx;
    logic                   clr_all;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        done_next    = done_reg;
        ack_next     = 1'b0;          // soft_ack is only ever a one-cycle pulse
        pending_next = pending_reg;
        src_next     = src_reg;
        rel_en       = 1'b0;
        rel_idx      = idx_reg;
        clr_all      = 1'b0;

        case (state_reg)
            ST_ASSERT: begin
                // Requests during a running sequence queue one restart.
                if (soft_req) begin
                    pending_next = 1'b1;
                end
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                    idx_next   = '0;
                    rel_en     = 1'b1;
                    rel_idx    = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_RELEASE: begin
                if (soft_req) begin
                    pending_next = 1'b1;
                end
                if (cnt_reg == GAP_LAST) begin
                    if (idx_reg == IDX_LAST) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                        ack_next   = src_reg;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                        rel_en   = 1'b1;
                        rel_idx  = idx_reg + IDX_W'(1);
                        cnt_next = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_DONE: begin
                // A queued request restarts one cycle after DONE entry, so
                // seq_done/soft_ack of the finished sequence still show for a cycle.
                if (pending_reg || soft_req) begin
                    state_next   = ST_ASSERT;
                    clr_all      = 1'b1;
                    done_next    = 1'b0;
                    cnt_next     = '0;
                    idx_next     = '0;
                    pending_next = 1'b0;
                    src_next     = 1'b1;
                end
            end

            default: begin
                state_next = ST_ASSERT;
                clr_all    = 1'b1;
                done_next  = 1'b0;
                cnt_next   = '0;
                idx_next   = '0;
            end
        endcase
    end

    // Released bits are sticky until the next ASSERT entry; each bit only
    // sets on its own release strobe, which keeps releases in index order.
    for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
        assign dom_next[gi] = clr_all ? 1'b0
                            : (dom_reg[gi] | (rel_en && (rel_idx == IDX_W'(gi))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_ASSERT;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            dom_reg     <= '0;
            done_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            pending_reg <= 1'b0;
            src_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            dom_reg     <= dom_next;
            done_reg    <= done_next;
            ack_reg     <= ack_next;
            pending_reg <= pending_next;
            src_reg     <= src_next;
        end
    end

    assign dom_rst_n = dom_reg;
    assign seq_done  = done_reg;
    assign soft_ack  = ack_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for rst_sequencer. Main instance uses default parameters and is
// checked against a schedule model. The model tracks the number of edges since
// the current sequence started and derives the outputs from the release
// schedule. A second instance with NUM_DOMAINS=HOLD=GAP=1 covers the minimal
// configuration.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

    localparam int N = 4;
    localparam int H = 8;
    localparam int G = 4;
    localparam int T = H + N * G;   // edges from sequence start to done

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         soft_req = 1'b0;
    logic [N-1:0] dom_rst_n;
    logic         seq_done;
    logic         soft_ack;

    logic         rst2 = 1'b1;
    logic         soft2 = 1'b0;
    logic [0:0]   dom2;
    logic         done2;
    logic         ack2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rst_sequencer #(.NUM_DOMAINS(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk       (clk),
        .rst       (rst),
        .soft_req  (soft_req),
        .dom_rst_n (dom_rst_n),
        .seq_done  (seq_done),
        .soft_ack  (soft_ack)
    );

    rst_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_min (
        .clk       (clk),
        .rst       (rst2),
        .soft_req  (soft2),
        .dom_rst_n (dom2),
        .seq_done  (done2),
        .soft_ack  (ack2)
    );

    // ---------------- schedule model ----------------
    // m_e: edges elapsed since the current sequence started (saturates at T).
    int m_e    = 0;
    bit m_src  = 0;
    bit m_pend = 0;
    bit m_ack  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_e = 0; m_src = 0; m_pend = 0; m_ack = 0;
        end else if (m_e >= T) begin
            m_ack = 0;
            if (m_pend || soft_req) begin
                m_e = 0; m_src = 1; m_pend = 0;
            end
        end else begin
            if (soft_req) m_pend = 1;
            m_e++;
            m_ack = (m_e == T) && m_src;
        end
    end

    function automatic logic [N-1:0] exp_dom();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (m_e >= H + i * G);
        return r;
    endfunction

    function automatic logic exp_done();
        return (m_e >= T);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; soft_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (dom_rst_n !== 4'b0000 || seq_done !== 1'b0 || soft_ack !== 1'b0) begin
                failures++;
                $display("FAIL reset: got dom=%b done=%b ack=%b, want dom=0000 done=0 ack=0",
                         dom_rst_n, seq_done, soft_ack);
            end
        end
    endtask

    task automatic test_initial_sequence();
        int acks = 0;
        logic [N-1:0] spot;
        bit spot_en;
        rst = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            step();
            acks += int'(soft_ack);
            checks++;
            if (dom_rst_n !== exp_dom() || seq_done !== exp_done() || soft_ack !== m_ack) begin
                failures++;
                $display("FAIL init_model edge %0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                         k, dom_rst_n, seq_done, soft_ack, exp_dom(), exp_done(), m_ack);
            end
            spot_en = 1'b1;
            case (k)
                7:       spot = 4'b0000;
                8:       spot = 4'b0001;
                11:      spot = 4'b0001;
                12:      spot = 4'b0011;
                16:      spot = 4'b0111;
                20:      spot = 4'b1111;
                default: begin spot = 4'b0000; spot_en = 1'b0; end
            endcase
            if (spot_en) begin
                checks++;
                if (dom_rst_n !== spot) begin
                    failures++;
                    $display("FAIL init_release edge %0d: got dom=%b, want %b", k, dom_rst_n, spot);
                end
            end
            if (k == 23 || k == 24) begin
                checks++;
                if (seq_done !== (k == 24)) begin
                    failures++;
                    $display("FAIL init_done edge %0d: got %b, want %0d", k, seq_done, k == 24);
                end
            end
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL init_no_ack: got %0d ack pulses, want 0", acks);
        end
        $display("initial sequence: dom=%b done=%b acks=%0d", dom_rst_n, seq_done, acks);
    endtask

    task automatic test_soft_request();
        int acks = 0;
        soft_req = 1'b1;
        step();                         // edge 30
        soft_req = 1'b0;
        checks++;
        if (dom_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
            failures++;
            $display("FAIL soft_assert: got dom=%b done=%b, want dom=0000 done=0", dom_rst_n, seq_done);
        end
        for (int k = 31; k <= 56; k++) begin
            step();
            acks += int'(soft_ack);
            checks++;
            if (dom_rst_n !== exp_dom() || seq_done !== exp_done() || soft_ack !== m_ack) begin
                failures++;
                $display("FAIL soft_model edge %0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                         k, dom_rst_n, seq_done, soft_ack, exp_dom(), exp_done(), m_ack);
            end
            if (k == 38 || k == 50) begin
                checks++;
                if (dom_rst_n !== ((k == 38) ? 4'b0001 : 4'b1111)) begin
                    failures++;
                    $display("FAIL soft_release edge %0d: got dom=%b", k, dom_rst_n);
                end
            end
            if (k == 54 || k == 55) begin
                checks++;
                if (soft_ack !== (k == 54) || seq_done !== 1'b1) begin
                    failures++;
                    $display("FAIL soft_ack edge %0d: got ack=%b done=%b, want ack=%0d done=1",
                             k, soft_ack, seq_done, k == 54);
                end
            end
        end
        checks++;
        if (acks != 1) begin
            failures++;
            $display("FAIL soft_ack_count: got %0d, want 1", acks);
        end
        $display("soft request: dom=%b done=%b acks=%0d", dom_rst_n, seq_done, acks);
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        soft_req = 1'b1;
        step();
        for (int j = 1; j <= 2 * T + 10; j++) begin
            soft_req = (j == 10 || j == 15);
            step();
            acks += int'(soft_ack);
            checks++;
            if (dom_rst_n !== exp_dom() || seq_done !== exp_done() || soft_ack !== m_ack) begin
                failures++;
                $display("FAIL b2b_model step %0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                         j, dom_rst_n, seq_done, soft_ack, exp_dom(), exp_done(), m_ack);
            end
            // Pending request: done for exactly one cycle, then restart.
            if (j == T || j == T + 1) begin
                checks++;
                if (seq_done !== (j == T) || soft_ack !== (j == T)) begin
                    failures++;
                    $display("FAIL b2b_handoff step %0d: got done=%b ack=%b, want both %0d",
                             j, seq_done, soft_ack, j == T);
                end
            end
        end
        soft_req = 1'b0;
        checks++;
        if (acks != 2 || seq_done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ack_count: got acks=%0d done=%b, want acks=2 done=1", acks, seq_done);
        end
        $display("back to back: acks=%0d done=%b", acks, seq_done);
    endtask

    task automatic test_mid_reset();
        int acks = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            soft_req = (k == 10);
            step();
        end
        soft_req = 1'b0;
        checks++;
        if (dom_rst_n !== 4'b0011) begin
            failures++;
            $display("FAIL mid_pre: got dom=%b, want 0011", dom_rst_n);
        end
        rst = 1'b1;
        step();                         // edge 14 with rst
        rst = 1'b0;
        checks++;
        if (dom_rst_n !== 4'b0000 || seq_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got dom=%b done=%b, want dom=0000 done=0", dom_rst_n, seq_done);
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            acks += int'(soft_ack);
            checks++;
            if (dom_rst_n !== exp_dom() || seq_done !== exp_done() || soft_ack !== m_ack) begin
                failures++;
                $display("FAIL mid_model edge %0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                         k, dom_rst_n, seq_done, soft_ack, exp_dom(), exp_done(), m_ack);
            end
        end
        checks++;
        if (acks != 0 || seq_done !== 1'b1 || dom_rst_n !== 4'b1111) begin
            failures++;
            $display("FAIL mid_rerun: got acks=%0d done=%b dom=%b, want acks=0 done=1 dom=1111",
                     acks, seq_done, dom_rst_n);
        end
        $display("mid reset: dom=%b done=%b acks=%0d", dom_rst_n, seq_done, acks);
    endtask

    task automatic test_reset_with_soft();
        int acks = 0;
        rst = 1'b1; soft_req = 1'b1;
        step();
        rst = 1'b0; soft_req = 1'b0;
        for (int k = 1; k <= T + 16; k++) begin
            step();
            acks += int'(soft_ack);
            checks++;
            if (dom_rst_n !== exp_dom() || seq_done !== exp_done() || soft_ack !== m_ack) begin
                failures++;
                $display("FAIL rstsoft_model edge %0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                         k, dom_rst_n, seq_done, soft_ack, exp_dom(), exp_done(), m_ack);
            end
        end
        checks++;
        if (acks != 0 || seq_done !== 1'b1) begin
            failures++;
            $display("FAIL rstsoft_dropped: got acks=%0d done=%b, want acks=0 done=1", acks, seq_done);
        end
        $display("reset with soft: done=%b acks=%0d", seq_done, acks);
    endtask

    task automatic test_random();
        int errs = 0;
        for (int k = 0; k < 800; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            soft_req = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (dom_rst_n !== exp_dom() || seq_done !== exp_done() || soft_ack !== m_ack) begin
                failures++;
                errs++;
                $display("FAIL random_model cycle %0d: got dom=%b done=%b ack=%b, want dom=%b done=%b ack=%b",
                         k, dom_rst_n, seq_done, soft_ack, exp_dom(), exp_done(), m_ack);
            end
        end
        rst = 1'b0; soft_req = 1'b0;
        $display("random: 800 cycles, %0d errors", errs);
    endtask

    task automatic test_minimal_params();
        rst2 = 1'b1;
        step();
        step();
        rst2 = 1'b0;
        step();                         // edge 1
        checks++;
        if (dom2 !== 1'b1 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL min_release: got dom=%b done=%b, want dom=1 done=0", dom2, done2);
        end
        step();                         // edge 2
        checks++;
        if (done2 !== 1'b1 || ack2 !== 1'b0) begin
            failures++;
            $display("FAIL min_done: got done=%b ack=%b, want done=1 ack=0", done2, ack2);
        end
        step();
        soft2 = 1'b1;
        step();                         // edge S
        soft2 = 1'b0;
        checks++;
        if (dom2 !== 1'b0 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL min_soft_assert: got dom=%b done=%b, want dom=0 done=0", dom2, done2);
        end
        step();                         // S+1
        checks++;
        if (dom2 !== 1'b1 || done2 !== 1'b0) begin
            failures++;
            $display("FAIL min_soft_release: got dom=%b done=%b, want dom=1 done=0", dom2, done2);
        end
        step();                         // S+2
        checks++;
        if (done2 !== 1'b1 || ack2 !== 1'b1) begin
            failures++;
            $display("FAIL min_soft_done: got done=%b ack=%b, want done=1 ack=1", done2, ack2);
        end
        step();                         // S+3
        checks++;
        if (done2 !== 1'b1 || ack2 !== 1'b0) begin
            failures++;
            $display("FAIL min_ack_pulse: got done=%b ack=%b, want done=1 ack=0", done2, ack2);
        end
        $display("minimal params: dom=%b done=%b ack=%b", dom2, done2, ack2);
    endtask

    initial begin
        test_reset();
        test_initial_sequence();
        test_soft_request();
        test_back_to_back();
        test_mid_reset();
        test_reset_with_soft();
        test_random();
        test_minimal_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
